// File: rtl/prbs_lane_checker.sv
// prbs_lane_checker: self-synchronising PRBS-7/15/23/31 lane checker with hunt/lock and saturating statistics
module prbs_lane_checker #(
   parameter int DATA_W   = 32,
   parameter int PRBS_N   = 31,
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 32
) (
   input  logic                 rx_user_clk_i,
   input  logic                 rx_user_rst_i,
   input  logic                 clear_i,
   input  logic [DATA_W-1:0]    rx_data_i,
   input  logic [DATA_W/16-1:0] rx_vldb_i,
   input  logic                 rx_valid_i,
   input  logic                 rx_last_i,
   input  logic                 rx_user_i,
   output logic                 locked_o,
   output logic                 err_o,
   output logic [CNT_W-1:0]     err_beat_cnt_o,
   output logic [CNT_W-1:0]     err_bit_cnt_o,
   output logic [CNT_W-1:0]     frame_cnt_o,
   output logic [CNT_W-1:0]     frame_err_cnt_o
);
   localparam int TAP = PRBS_N == 7 ? 6 : PRBS_N == 15 ? 14 : PRBS_N == 23 ? 18 : PRBS_N == 31 ? 28 : 0;
   localparam int PC_W = $clog2(DATA_W + 1);
   localparam int SUM_W = (CNT_W > PC_W ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);
   localparam logic [7:0] LOSS_V = 8'(LOSS_CNT);

   generate
      if (TAP == 0 || DATA_W < PRBS_N || DATA_W % 16 != 0 || LOCK_CNT < 1 || LOCK_CNT > 255 ||
          LOSS_CNT < 1 || LOSS_CNT > 255) begin : g_bad_param
         $error("prbs_lane_checker: illegal parameter combination");
      end
   endgenerate

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t             state;
   logic               have_prev;
   logic [DATA_W-1:0]  ref_q;
   logic [DATA_W-1:0]  exp_w;
   logic [DATA_W-1:0]  diff;
   logic [7:0]         good_run;
   logic [7:0]         bad_run;
   logic               acc;
   logic               mism;
   logic [PC_W-1:0]    pop;
   logic [SUM_W-1:0]   bit_sum;

   // Extend the reference word by DATA_W stream bits using s[k] = s[k-N] ^ s[k-T]
   function automatic logic [DATA_W-1:0] predict(input logic [DATA_W-1:0] r);
      logic [2*DATA_W-1:0] s;
      s = {{DATA_W{1'b0}}, r};
      for (int i = DATA_W; i < 2*DATA_W; i++) s[i] = s[i-PRBS_N] ^ s[i-TAP];
      return s[2*DATA_W-1:DATA_W];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return c == CNT_MAX ? c : c + 1'b1;
   endfunction

   // Beat acceptance, prediction, compare and errored-bit accumulation
   always_comb begin
      acc = rx_valid_i && &rx_vldb_i;
      exp_w = predict(ref_q);
      diff = rx_data_i ^ exp_w;
      mism = |diff;
      pop = '0;
      for (int i = 0; i < DATA_W; i++) pop = pop + PC_W'(diff[i]);
      bit_sum = SUM_W'(err_bit_cnt_o) + SUM_W'(pop);
   end

   // Hunt/lock sequencing; in LOCKED the reference follows the prediction so errors never propagate
   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i)
      if (rx_user_rst_i) begin
         state     <= HUNT;
         have_prev <= 1'b0;
         ref_q     <= '0;
         good_run  <= '0;
         bad_run   <= '0;
         locked_o  <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (acc) begin
            if (state == HUNT) begin
               ref_q     <= rx_data_i;
               have_prev <= 1'b1;
               if (have_prev) begin
                  if (mism) good_run <= '0;
                  else if (good_run + 8'd1 == LOCK_V) begin
                     state    <= LOCKED;
                     locked_o <= 1'b1;
                     good_run <= '0;
                     bad_run  <= '0;
                  end else good_run <= good_run + 8'd1;
               end
            end else begin
               ref_q <= exp_w;
               err_o <= mism;
               if (!mism) bad_run <= '0;
               else if (bad_run + 8'd1 == LOSS_V) begin
                  state     <= HUNT;
                  locked_o  <= 1'b0;
                  have_prev <= 1'b0;
                  good_run  <= '0;
                  bad_run   <= '0;
               end else bad_run <= bad_run + 8'd1;
            end
         end
      end

   // Saturating statistics; a clear wins over any increment on the same edge
   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i)
      if (rx_user_rst_i || clear_i) begin
         err_beat_cnt_o  <= '0;
         err_bit_cnt_o   <= '0;
         frame_cnt_o     <= '0;
         frame_err_cnt_o <= '0;
      end else begin
         if (acc && state == LOCKED && mism) begin
            err_beat_cnt_o <= sat_inc(err_beat_cnt_o);
            err_bit_cnt_o  <= bit_sum > SUM_W'(CNT_MAX) ? CNT_MAX : bit_sum[CNT_W-1:0];
         end
         if (rx_valid_i && rx_last_i) begin
            frame_cnt_o <= sat_inc(frame_cnt_o);
            if (rx_user_i) frame_err_cnt_o <= sat_inc(frame_err_cnt_o);
         end
      end
endmodule

// File: tb/tb_prbs_lane_checker.sv
// tb_prbs_lane_checker: directed checks of lock, error counting, partial beats, saturation, clear and reset
module tb_prbs_lane_checker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic        a_clear = 0, a_valid = 0, a_last = 0, a_user = 0;
   logic [31:0] a_data = '0;
   logic [1:0]  a_vldb = '0;
   logic        a_locked, a_err;
   logic [31:0] a_eb, a_ebit, a_fc, a_fec;

   logic        b_clear = 0, b_valid = 0, b_last = 0, b_user = 0;
   logic [31:0] b_data = '0;
   logic [1:0]  b_vldb = '0;
   logic        b_locked, b_err;
   logic [3:0]  b_eb, b_ebit, b_fc, b_fec;

   logic [30:0] sr_a = 31'h1234_5678;
   logic [6:0]  sr_b = 7'h5A;
   logic [31:0] w;

   always #5 clk = ~clk;

   prbs_lane_checker dut_a (
      .rx_user_clk_i(clk), .rx_user_rst_i(rst), .clear_i(a_clear),
      .rx_data_i(a_data), .rx_vldb_i(a_vldb), .rx_valid_i(a_valid),
      .rx_last_i(a_last), .rx_user_i(a_user),
      .locked_o(a_locked), .err_o(a_err),
      .err_beat_cnt_o(a_eb), .err_bit_cnt_o(a_ebit),
      .frame_cnt_o(a_fc), .frame_err_cnt_o(a_fec)
   );

   prbs_lane_checker #(.DATA_W(32), .PRBS_N(7), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(4)) dut_b (
      .rx_user_clk_i(clk), .rx_user_rst_i(rst), .clear_i(b_clear),
      .rx_data_i(b_data), .rx_vldb_i(b_vldb), .rx_valid_i(b_valid),
      .rx_last_i(b_last), .rx_user_i(b_user),
      .locked_o(b_locked), .err_o(b_err),
      .err_beat_cnt_o(b_eb), .err_bit_cnt_o(b_ebit),
      .frame_cnt_o(b_fc), .frame_err_cnt_o(b_fec)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Serial Fibonacci LFSRs: sr[0] is the newest bit, word bit 0 is the earliest
   task automatic gen_a(output logic [31:0] o);
      logic nb;
      for (int i = 0; i < 32; i++) begin
         nb = sr_a[30] ^ sr_a[27];
         sr_a = {sr_a[29:0], nb};
         o[i] = nb;
      end
   endtask

   task automatic gen_b(output logic [31:0] o);
      logic nb;
      for (int i = 0; i < 32; i++) begin
         nb = sr_b[6] ^ sr_b[5];
         sr_b = {sr_b[5:0], nb};
         o[i] = nb;
      end
   endtask

   task automatic beat_a(input logic [31:0] d, input logic [1:0] vb, input logic v, input logic l, input logic u);
      a_data = d; a_vldb = vb; a_valid = v; a_last = l; a_user = u;
      @(posedge clk); #1;
      a_valid = 0; a_last = 0; a_user = 0;
   endtask

   task automatic beat_b(input logic [31:0] d, input logic [1:0] vb, input logic v, input logic l, input logic u);
      b_data = d; b_vldb = vb; b_valid = v; b_last = l; b_user = u;
      @(posedge clk); #1;
      b_valid = 0; b_last = 0; b_user = 0;
   endtask

   task automatic clean_a(input int n);
      logic [31:0] x;
      repeat (n) begin gen_a(x); beat_a(x, 2'b11, 1, 0, 0); end
   endtask

   task automatic bad_a(input logic [31:0] mask);
      logic [31:0] x;
      gen_a(x); beat_a(x ^ mask, 2'b11, 1, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #2 rst = 1;
      #5;
      chk("rst_a_locked", 32'(a_locked), 0);
      chk("rst_a_err", 32'(a_err), 0);
      chk("rst_a_eb", a_eb, 0);
      chk("rst_a_ebit", a_ebit, 0);
      chk("rst_a_fc", a_fc, 0);
      chk("rst_a_fec", a_fec, 0);
      chk("rst_b_locked", 32'(b_locked), 0);
      @(posedge clk); #1 rst = 0;

      clean_a(8);
      chk("a_lock_after8", 32'(a_locked), 0);
      clean_a(1);
      chk("a_lock_after9", 32'(a_locked), 1);
      clean_a(200);
      chk("a_clean_locked", 32'(a_locked), 1);
      chk("a_clean_eb", a_eb, 0);
      chk("a_clean_ebit", a_ebit, 0);

      bad_a(32'h0002_0021);
      chk("a_3bit_err", 32'(a_err), 1);
      chk("a_3bit_eb", a_eb, 1);
      chk("a_3bit_ebit", a_ebit, 3);
      clean_a(1);
      chk("a_err_pulse_end", 32'(a_err), 0);
      chk("a_still_locked", 32'(a_locked), 1);
      clean_a(10);
      chk("a_noprop_eb", a_eb, 1);
      chk("a_noprop_ebit", a_ebit, 3);

      idle(5);
      beat_a(32'hDEAD_BEEF, 2'b01, 1, 1, 1);
      chk("a_partial_err", 32'(a_err), 0);
      chk("a_partial_fc", a_fc, 1);
      chk("a_partial_fec", a_fec, 1);
      beat_a(32'hDEAD_BEEF, 2'b11, 0, 1, 1);
      chk("a_invalid_last_fc", a_fc, 1);
      clean_a(5);
      chk("a_after_partial_eb", a_eb, 1);
      chk("a_after_partial_locked", 32'(a_locked), 1);

      a_clear = 1; idle(1); a_clear = 0;
      chk("a_clear_eb", a_eb, 0);
      chk("a_clear_ebit", a_ebit, 0);
      chk("a_clear_fc", a_fc, 0);
      chk("a_clear_locked", 32'(a_locked), 1);

      repeat (3) bad_a(32'h1);
      chk("a_loss3_locked", 32'(a_locked), 1);
      chk("a_loss3_eb", a_eb, 3);
      bad_a(32'h1);
      chk("a_loss4_locked", 32'(a_locked), 0);
      chk("a_loss4_eb", a_eb, 4);
      chk("a_loss4_ebit", a_ebit, 4);
      chk("a_loss4_err", 32'(a_err), 1);

      bad_a(32'h10);
      chk("a_hunt_first_err", 32'(a_err), 0);
      clean_a(1);
      chk("a_hunt_mism_err", 32'(a_err), 0);
      chk("a_hunt_mism_eb", a_eb, 4);
      chk("a_hunt_mism_locked", 32'(a_locked), 0);
      clean_a(7);
      chk("a_relock_7", 32'(a_locked), 0);
      clean_a(1);
      chk("a_relock_8", 32'(a_locked), 1);

      for (int i = 1; i <= 9; i++) begin
         gen_b(w); beat_b(w, 2'b11, 1, (i % 3 == 0), 0);
         if (i == 8) chk("b_lock_after8", 32'(b_locked), 0);
         idle(1);
         beat_b(32'hA5A5_5A5A, 2'b10, 1, (i % 2 == 1), 0);
      end
      chk("b_lock_gaps", 32'(b_locked), 1);
      chk("b_frames_partial", 32'(b_fc), 8);
      for (int i = 1; i <= 6; i++) begin
         beat_b(32'h0F0F_F0F0, 2'b01, 1, 0, 0);
         gen_b(w); beat_b(w, 2'b11, 1, 0, 0);
         idle(1);
      end
      chk("b_gaps_locked", 32'(b_locked), 1);
      chk("b_gaps_eb", 32'(b_eb), 0);
      chk("b_gaps_fc", 32'(b_fc), 8);
      for (int j = 1; j <= 20; j++) begin
         gen_b(w); beat_b(w, 2'b11, 1, 1, 1);
         if (j == 7) begin
            chk("b_fec_7", 32'(b_fec), 7);
            chk("b_fc_sat", 32'(b_fc), 15);
         end
      end
      chk("b_fec_sat", 32'(b_fec), 15);
      chk("b_fc_sat_hold", 32'(b_fc), 15);
      gen_b(w); beat_b(w ^ 32'hFFFF_FFFF, 2'b11, 1, 0, 0);
      chk("b_full_err", 32'(b_err), 1);
      chk("b_full_eb", 32'(b_eb), 1);
      chk("b_bit_sat", 32'(b_ebit), 15);
      gen_b(w); beat_b(w, 2'b11, 1, 0, 0);
      chk("b_err_clear_pulse", 32'(b_err), 0);
      b_clear = 1;
      gen_b(w); beat_b(w ^ 32'h3, 2'b11, 1, 0, 0);
      b_clear = 0;
      chk("b_clr_err_o", 32'(b_err), 1);
      chk("b_clr_eb", 32'(b_eb), 0);
      chk("b_clr_ebit", 32'(b_ebit), 0);
      chk("b_clr_fc", 32'(b_fc), 0);
      chk("b_clr_fec", 32'(b_fec), 0);
      chk("b_clr_locked", 32'(b_locked), 1);
      gen_b(w); beat_b(w, 2'b11, 1, 0, 0);
      chk("b_post_clr_eb", 32'(b_eb), 0);

      gen_a(w); beat_a(w, 2'b11, 1, 1, 0);
      chk("a_pre_rst_fc", a_fc, 1);
      clean_a(1);
      #3 rst = 1;
      #1;
      chk("a_async_locked", 32'(a_locked), 0);
      chk("a_async_eb", a_eb, 0);
      chk("a_async_ebit", a_ebit, 0);
      chk("a_async_fc", a_fc, 0);
      @(posedge clk); #1 rst = 0;
      clean_a(8);
      chk("a_rst_relock_8", 32'(a_locked), 0);
      clean_a(1);
      chk("a_rst_relock_9", 32'(a_locked), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prbs_lane_checker.md
Name: prbs_lane_checker

Overview:
- Parametrised, self-synchronising PRBS checker for one lane of the xm_top AXIS RX stream. Next generation of the per-lane checker.
- Supports PRBS-7/15/23/31 and configurable data width.
- Has a hunt/lock state machine, saturating beat, bit and frame error counters, and a software clear.
- One instance per lane sits on the RX user clock domain; locked_o and err_o feed the board debug OR.

Parameters:
- DATA_W, 32, rx data width in bits. Must be a multiple of 16 and must be >= PRBS_N.
- PRBS_N, 31, polynomial order (7, 15, 23 or 31). Polynomials: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
- LOCK_CNT, 8, consecutive matching beats required to lock (1..255).
- LOSS_CNT, 4, consecutive errored beats that drop lock (1..255).
- CNT_W, 32, width of every statistics counter.

Ports:
- rx_user_clk_i  in  1  RX user clock. The only clock.
- rx_user_rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous pulse that zeroes all counters.
- rx_data_i  in  DATA_W  received data. Bit 0 is earliest in time.
- rx_vldb_i  in  DATA_W/16  per-16-bit-half valid flags.
- rx_valid_i  in  1  beat valid.
- rx_last_i  in  1  end of frame.
- rx_user_i  in  1  MAC frame-error flag, sampled on the last beat.
- locked_o  out  1  checker is in LOCKED.
- err_o  out  1  one-cycle pulse per errored beat while LOCKED.
- err_beat_cnt_o  out  CNT_W  errored beats counted while LOCKED.
- err_bit_cnt_o  out  CNT_W  errored bits counted while LOCKED.
- frame_cnt_o  out  CNT_W  frames received.
- frame_err_cnt_o  out  CNT_W  frames whose last beat had rx_user_i=1.

Behaviour:
- Reset (async assert, sync release): state HUNT, have_prev=0, run counters 0, all outputs 0.
- Accepted beat: rx_valid_i=1 and rx_vldb_i all ones. Partial beats are not compared and do not advance prediction, but rx_last_i/rx_user_i on them still count.
- Prediction: stream bit s[k] = s[k-N] ^ s[k-T]. Expected beat is computed combinationally from the reference word (previous DATA_W bits), bit 0 first.
- Reference word in HUNT: the previous accepted received beat.
- Reference word in LOCKED: the previous expected beat, so errors do not propagate.
- HUNT:
  - First accepted beat: set have_prev=1, store the beat, no compare.
  - Later beats: match increments good_run, mismatch clears it; the received beat is always stored.
  - When good_run reaches LOCK_CNT, go to LOCKED on that edge. Reference = that received beat. bad_run=0.
- LOCKED:
  - Compare each accepted beat against the prediction.
  - Mismatch: err_o=1 on the next cycle; err_beat_cnt +1; err_bit_cnt += popcount(xor), saturating; bad_run +1.
  - Match: bad_run=0.
  - When bad_run reaches LOSS_CNT, go to HUNT with good_run=0 and have_prev=0.
- No errors are counted in HUNT.
- locked_o is registered and tracks state with one cycle latency from the deciding beat. err_o and all counter updates are also registered, one cycle after the beat.
- Frame counting: rx_valid_i & rx_last_i increments frame_cnt; if rx_user_i is also 1, frame_err_cnt increments as well.
- Saturation: every counter holds at 2^CNT_W-1. err_bit_cnt is clamped when the add would overflow.
- clear_i zeroes all four counters on the next edge and has priority over a simultaneous increment (that increment is lost). It does not affect state, run counters or err_o.
- rx_valid_i=0 cycles hold all state. Gaps do not break lock.
- Reset asserted mid-frame or while LOCKED: immediate return to reset values. After release, relock needs 1+LOCK_CNT clean beats.
- Illegal parameters (DATA_W<PRBS_N, PRBS_N not in the set) fail elaboration.

Test Plan:
- Clean PRBS-31 stream, DATA_W=32, LOCK_CNT=8, back-to-back beats -> locked_o rises 1 cycle after beat 9; counters stay 0 over 10^5 beats.
- Locked; flip bits 0, 5, 17 of one beat -> single err_o pulse, err_beat_cnt=1, err_bit_cnt=3; following beats clean (no propagation).
- Locked, LOSS_CNT=4; corrupt 4 consecutive beats -> locked_o falls after the 4th, err_beat_cnt=4; clean stream then relocks after 9 further beats.
- PRBS_N=7, random rx_valid_i gaps and partial-vldb beats inserted -> lock held, no errors; frame_cnt equals the number of rx_last_i beats, partial-last frames included.
- CNT_W=4, 20 errored frames with rx_user_i=1 -> frame_err_cnt holds 15. clear_i asserted on the same cycle as an error -> counter reads 0.
- Assert rx_user_rst_i mid-frame while LOCKED -> all outputs 0 asynchronously; after release, relock within 9 clean beats.
